// File: rtl/i2c_bus_sniffer.sv
// Passive I2C bus monitor: synchronises and deglitches SCL/SDA, detects
// START/STOP, deserialises 9-bit transfers and flags an SCL-low stuck bus.
// Never drives the bus.
module i2c_bus_sniffer #(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       bus_busy,
  output logic       start_det,
  output logic       stop_det,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_is_addr,
  output logic       rw_bit,
  output logic       timeout
);

  localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BCW = 4;

  typedef enum logic {IDLE, RX} state_t;

  logic           scl_s1, scl_s2, sda_s1, sda_s2;
  logic           scl_f, sda_f, scl_d, sda_d;
  logic [FCW-1:0] scl_cnt, sda_cnt;
  logic [TCW-1:0] to_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [7:0]     shreg;
  logic           addr_flag;
  state_t         state;

  logic scl_rise_c, start_cond_c, stop_cond_c;

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

  // SCL deglitch: follow synced value only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_s2 == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == FCW'(FILT_LEN - 1)) begin
      scl_f   <= scl_s2;
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + FCW'(1);
    end
  end

  // SDA deglitch, same rule as SCL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_s2 == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == FCW'(FILT_LEN - 1)) begin
      sda_f   <= sda_s2;
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + FCW'(1);
    end
  end

  // One-cycle delayed copies of the filtered lines for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SDA edges only count as START/STOP while SCL is steadily high
  always_comb begin
    scl_rise_c   = scl_f & ~scl_d;
    start_cond_c = scl_f & scl_d & sda_d & ~sda_f;
    stop_cond_c  = scl_f & scl_d & ~sda_d & sda_f;
  end

  // Transfer FSM with registered event pulses, byte capture and stuck-SCL timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus_busy     <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_ack     <= 1'b0;
      byte_is_addr <= 1'b0;
      rw_bit       <= 1'b0;
      timeout      <= 1'b0;
      to_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      addr_flag    <= 1'b0;
    end else begin
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      byte_valid <= 1'b0;
      if (start_cond_c) begin
        timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (start_cond_c) begin
            state     <= RX;
            bit_cnt   <= '0;
            addr_flag <= 1'b1;
            start_det <= 1'b1;
            bus_busy  <= 1'b1;
          end else if (stop_cond_c) begin
            stop_det <= 1'b1;
          end
        end
        RX: begin
          if (scl_f) begin
            to_cnt <= '0;
          end else if (to_cnt == TCW'(TIMEOUT_CYC - 1)) begin
            timeout  <= 1'b1;
            bus_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
          if (start_cond_c) begin
            bit_cnt   <= '0;
            addr_flag <= 1'b1;
            start_det <= 1'b1;
          end else if (stop_cond_c) begin
            stop_det <= 1'b1;
            bus_busy <= 1'b0;
            state    <= IDLE;
          end else if (scl_rise_c) begin
            if (bit_cnt == BCW'(8)) begin
              byte_valid   <= 1'b1;
              byte_data    <= shreg;
              byte_ack     <= ~sda_f;
              byte_is_addr <= addr_flag;
              if (addr_flag) begin
                rw_bit <= shreg[0];
              end
              bit_cnt   <= '0;
              addr_flag <= 1'b0;
            end else begin
              shreg   <= {shreg[6:0], sda_f};
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_sniffer.sv
// Scoreboard bench for i2c_bus_sniffer: stimulus tasks push expected events,
// a negedge monitor pops and compares each DUT pulse.
module tb_i2c_bus_sniffer;

  localparam int unsigned FILT = 4;
  localparam int unsigned TOC  = 200;
  localparam int          Q    = 20;

  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_BYTE  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ack;
    logic       is_addr;
    logic       rw;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl_i, sda_i;
  logic       bus_busy, start_det, stop_det, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ack, byte_is_addr, rw_bit, timeout;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rw_m     = 1'b0;

  i2c_bus_sniffer #(.FILT_LEN(FILT), .TIMEOUT_CYC(TOC)) dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl_i), .sda_i(sda_i),
    .bus_busy(bus_busy), .start_det(start_det), .stop_det(stop_det),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ack(byte_ack),
    .byte_is_addr(byte_is_addr), .rw_bit(rw_bit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    if (kind == EV_BYTE && e.kind == EV_BYTE) begin
      chk("byte_data", 32'(byte_data), 32'(e.data));
      chk("byte_ack", 32'(byte_ack), 32'(e.ack));
      chk("byte_is_addr", 32'(byte_is_addr), 32'(e.is_addr));
      chk("rw_bit", 32'(rw_bit), 32'(e.rw));
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (start_det || stop_det || byte_valid)) begin
      chk("start_byte_excl", 32'(start_det & byte_valid), 32'd0);
      if (start_det)  pop_chk(EV_START);
      if (stop_det)   pop_chk(EV_STOP);
      if (byte_valid) pop_chk(EV_BYTE);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d, input logic a, input logic ia);
    ev_t e;
    e.kind = kind; e.data = d; e.ack = a; e.is_addr = ia; e.rw = rw_m;
    exp_q.push_back(e);
  endtask

  // Bus idle high -> START, leaves SCL low
  task automatic i2c_start();
    push_ev(EV_START, 8'h00, 1'b0, 1'b0);
    sda_i = 1'b0; clks(2 * Q);
    scl_i = 1'b0; clks(Q);
  endtask

  // From SCL low: release SDA, raise SCL, then START
  task automatic i2c_rstart();
    sda_i = 1'b1; clks(Q);
    scl_i = 1'b1; clks(2 * Q);
    i2c_start();
  endtask

  task automatic i2c_stop();
    push_ev(EV_STOP, 8'h00, 1'b0, 1'b0);
    sda_i = 1'b0; clks(Q);
    scl_i = 1'b1; clks(2 * Q);
    sda_i = 1'b1; clks(2 * Q);
  endtask

  // One bit; with g set, injects FILT-1 clk glitches on SDA (SCL high) and SCL (SCL low)
  task automatic send_bit(input logic b, input logic g);
    sda_i = b; clks(Q);
    scl_i = 1'b1;
    if (g) begin
      clks(10); sda_i = ~b; clks(FILT - 1); sda_i = b; clks(2 * Q - 10 - (FILT - 1));
    end else begin
      clks(2 * Q);
    end
    scl_i = 1'b0;
    if (g) begin
      clks(5); scl_i = 1'b1; clks(FILT - 1); scl_i = 1'b0; clks(Q - 5 - (FILT - 1));
    end else begin
      clks(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack, input logic ia, input logic g);
    if (ia) rw_m = d[0];
    push_ev(EV_BYTE, d, ack, ia);
    for (int i = 7; i >= 0; i--) send_bit(d[i], g);
    send_bit(~ack, g);
  endtask

  initial begin
    scl_i = 1'b1; sda_i = 1'b1; reset_n = 1'b0;
    clks(5);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_pulses", 32'({start_det, stop_det, byte_valid}), 32'd0);
    chk("rst_data", 32'({byte_data, byte_ack, byte_is_addr, rw_bit}), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    clks(10);

    // Write A0 ACK, 5A NACK, STOP
    i2c_start();
    chk("busy_after_start", 32'(bus_busy), 32'd1);
    send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b0);
    i2c_stop();
    chk("busy_after_stop", 32'(bus_busy), 32'd0);
    chk("no_timeout_1", 32'(timeout), 32'd0);

    // Write, repeated START, read
    i2c_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0, 1'b0);
    i2c_rstart();
    chk("busy_after_rstart", 32'(bus_busy), 32'd1);
    send_byte(8'hA1, 1'b1, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("busy_before_stop", 32'(bus_busy), 32'd1);
    i2c_stop();
    chk("busy_after_stop2", 32'(bus_busy), 32'd0);

    // Glitches of FILT-1 clks on every bit must be invisible
    i2c_start();
    send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
    send_byte(8'hC5, 1'b0, 1'b0, 1'b1);
    i2c_stop();

    // Partial byte then STOP, then a clean byte
    i2c_start();
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'h42, 1'b1, 1'b1, 1'b0);
    i2c_stop();

    // SCL stuck low -> timeout; next START clears it
    i2c_start();
    clks(TOC + 40);
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_busy", 32'(bus_busy), 32'd0);
    sda_i = 1'b1; clks(Q);
    scl_i = 1'b1; clks(2 * Q);
    chk("timeout_sticky", 32'(timeout), 32'd1);
    i2c_start();
    chk("timeout_cleared", 32'(timeout), 32'd0);
    chk("busy_after_to_start", 32'(bus_busy), 32'd1);
    send_byte(8'h91, 1'b0, 1'b1, 1'b0);
    i2c_stop();

    // Reset pulse mid-byte clears everything at once
    i2c_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(bus_busy), 32'd0);
    chk("midrst_data", 32'({byte_data, byte_ack, byte_is_addr, rw_bit}), 32'd0);
    chk("midrst_pulses", 32'({start_det, stop_det, byte_valid, timeout}), 32'd0);
    clks(1);
    reset_n = 1'b1;
    rw_m = 1'b0;
    clks(10);
    scl_i = 1'b1; clks(2 * Q);
    i2c_start();
    send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0, 1'b0);
    i2c_stop();
    chk("final_busy", 32'(bus_busy), 32'd0);

    clks(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
